// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the seq_pattern_tx serial frame transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int unsigned DEF_PATTERN_W  = 8;
  localparam logic [7:0]  DEF_PATTERN    = 8'b1000_0001;
  localparam int unsigned DEF_GAP_CYCLES = 2;
  localparam int unsigned DEF_CNT_W      = 4;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable MSB-first shift register with a down-counting bit index;
// last_o flags the cycle in which the frame's LSB sits at the output.
module seq_tx_shifter
  import seq_tx_pkg::*;
#(
  parameter int unsigned          PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic shift_i,
  output logic bit_o,
  output logic last_o
);

  localparam int unsigned IDX_W = cnt_width(PATTERN_W - 1);

  logic [PATTERN_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  // Load wins over shift so a frame can be reloaded on its own last bit.
  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    if (load_i) begin
      sreg_d = PATTERN;
      idx_d  = IDX_W'(PATTERN_W - 1);
    end else if (shift_i && (idx_q != '0)) begin
      sreg_d = {sreg_q[PATTERN_W-2:0], 1'b0};
      idx_d  = idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      idx_q  <= idx_d;
    end
  end

  assign bit_o  = sreg_q[PATTERN_W-1];
  assign last_o = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends N copies of PATTERN MSB-first on J with
// idle gaps between frames. Define SEQ_PATTERN_TX_PARITY_EN to append an
// even-parity bit after every frame.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned          PATTERN_W  = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN    = PATTERN_W'(DEF_PATTERN),
  parameter int unsigned          GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned          CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frames,
  output logic             J,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned GAP_W = cnt_width(GAP_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frames_left_q, frames_left_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             sh_load, sh_shift, sh_bit, sh_last;
  logic             frame_end, tx_bit;
  logic             j_d, valid_d, busy_d, done_d;

`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam logic PARITY_BIT = ^PATTERN;
  logic par_q, par_d;

  assign frame_end = (state_q == ST_SEND) && par_q;
  assign tx_bit    = par_q ? PARITY_BIT : sh_bit;
`else
  assign frame_end = (state_q == ST_SEND) && sh_last;
  assign tx_bit    = sh_bit;
`endif

  seq_tx_shifter #(
    .PATTERN_W (PATTERN_W),
    .PATTERN   (PATTERN)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .bit_o   (sh_bit),
    .last_o  (sh_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state, frame/gap counters and shifter control
  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    gap_cnt_d     = gap_cnt_q;
    sh_load       = 1'b0;
    sh_shift      = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    par_d         = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (frames != '0) begin
            frames_left_d = frames;
            sh_load       = 1'b1;
            state_d       = ST_SEND;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_SEND: begin
        sh_shift = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
        par_d    = sh_last && !par_q;
`endif
        if (frame_end) begin
          frames_left_d = frames_left_q - CNT_W'(1);
          if (frames_left_q > CNT_W'(1)) begin
            sh_load = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
            end
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_SEND;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; busy is withheld on a zero-frame start so it pairs with done
  always_comb begin
    j_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: busy_d = start && (frames != '0);
      ST_SEND: begin
        j_d     = tx_bit;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_GAP:  busy_d = 1'b1;
      ST_FIN: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frames_left_q <= '0;
      gap_cnt_q     <= '0;
      J             <= 1'b0;
      bit_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      frames_left_q <= frames_left_d;
      gap_cnt_q     <= gap_cnt_d;
      J             <= j_d;
      bit_valid     <= valid_d;
      busy          <= busy_d;
      done          <= done_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: expected J/bit_valid/busy/done
// traces are built from the frame/gap/parity rules and compared cycle by cycle.
module tb_seq_pattern_tx;

  localparam int unsigned PW    = 8;
  localparam int unsigned GAP   = 2;
  localparam int unsigned CW    = 4;
  localparam logic [7:0]  PAT   = 8'b1000_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] frames;
  logic          J, bit_valid, busy, done;

  int tests = 0;
  int fails = 0;

  seq_pattern_tx #(
    .PATTERN_W  (PW),
    .PATTERN    (PAT),
    .GAP_CYCLES (GAP),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frames    (frames),
    .J         (J),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ej, input logic ev,
                           input logic eb, input logic ed);
    check({tag, ".J"},         J,         ej);
    check({tag, ".bit_valid"}, bit_valid, ev);
    check({tag, ".busy"},      busy,      eb);
    check({tag, ".done"},      done,      ed);
  endtask

  // Build the expected serial stream for n frames, start them and check every
  // cycle from acceptance until busy has dropped again.
  task automatic run_frames(input int n, input bit junk, input string tag);
    logic [1:0] bq[$];
    logic [7:0] pat_v;
    logic       par;
    int         len;
    logic       ej, ev, eb, ed;
    pat_v = PAT;
    par   = ^pat_v;
    for (int f = 0; f < n; f++) begin
      for (int b = PW - 1; b >= 0; b--) bq.push_back({1'b1, pat_v[b]});
`ifdef SEQ_PATTERN_TX_PARITY_EN
      bq.push_back({1'b1, par});
`endif
      if (f < n - 1) for (int g = 0; g < GAP; g++) bq.push_back(2'b00);
    end
    len    = bq.size();
    start  = 1'b1;
    frames = CW'(n);
    tick();
    start  = 1'b0;
    for (int t = 0; t <= len + 2; t++) begin
      ev = (t >= 1 && t <= len) ? bq[t-1][1] : 1'b0;
      ej = (t >= 1 && t <= len) ? bq[t-1][0] : 1'b0;
      eb = (t <= len + 1) && ((n > 0) || (t == len + 1));
      ed = (t == len + 1);
      check_all($sformatf("%s[n=%0d,t=%0d]", tag, n, t), ej, ev, eb, ed);
      if (junk && t <= len) begin
        start  = 1'($urandom);
        frames = CW'($urandom);
      end else begin
        start  = 1'b0;
        frames = '0;
      end
      if (t < len + 2) tick();
    end
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    frames = '0;
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    run_frames(1, 1'b0, "single");
    run_frames(3, 1'b0, "triple");
    run_frames(0, 1'b0, "zero");

    // Abort mid-frame: no done, all outputs cleared, then a clean frame
    start  = 1'b1;
    frames = CW'(2);
    tick();
    start  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort.pre_valid", bit_valid, 1'b1);
    rst = 1'b0;
    tick();
    check_all("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("abort.after%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_frames(1, 1'b0, "post_abort");

    // Start pulses and frame-count changes while busy must be ignored
    run_frames(2, 1'b1, "junk");
    for (int r = 0; r < 12; r++) begin
      run_frames(int'($urandom_range(0, 5)), 1'(r % 2), "rand");
      repeat ($urandom_range(0, 2)) begin
        tick();
        check_all("rand.idle", 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter; the generating end of the 1-bit "J" line consumed by the s10000001detectorQ sequence detector.
- On a start request it shifts out a fixed W-bit frame (default 10000001), MSB first, one bit per clock.
- It can send back-to-back repeated frames separated by an idle gap.
- Used as on-chip stimulus and loopback source for detector validation.

Parameters:
- PATTERN_W, 8, frame length in bits (>=2).
- PATTERN, 8'b10000001, frame contents; MSB transmitted first.
- GAP_CYCLES, 2, idle-zero cycles inserted between consecutive frames (0 allowed = back-to-back).
- CNT_W, 4, width of the frame-count input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising clk edge.
- start  input  1  request; sampled only in IDLE.
- frames  input  CNT_W  number of frames to send; latched when start is accepted.
- J  output  1  serial data, registered.
- bit_valid  output  1  high while J carries a frame (or parity) bit.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (rst==0 at edge): state=IDLE, J=0, bit_valid=0, busy=0, done=0, all counters cleared. Reset overrides every other input, including mid-frame; an aborted transfer produces no done pulse.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE:
  - start=1 and frames!=0: latch frames into frames_left; load shift reg with PATTERN; go to SEND.
  - start=1 and frames==0: go directly to FIN; no bits sent; busy high 1 cycle with done.
  - start=0: stay; J=0.
- Latency: start sampled at edge k -> MSB of frame on J and bit_valid=1 after edge k+1 (registered output, 1 cycle). busy=1 from edge k.
- SEND: one bit per cycle, bit index counts PATTERN_W-1 down to 0. After the LSB cycle:
  - frames_left>1 and GAP_CYCLES>0: go to GAP.
  - frames_left>1 and GAP_CYCLES==0: reload PATTERN, stay in SEND (no bubble).
  - Last frame: go to FIN.
  - frames_left decrements at each frame end.
- GAP: J=0, bit_valid=0 for exactly GAP_CYCLES cycles; then reload PATTERN -> SEND.
- FIN: done=1, busy=1 for one cycle; J=0, bit_valid=0; next state IDLE. busy=0 from the following cycle.
- start while busy: ignored, not queued. start in the FIN cycle: ignored. A new start is accepted no earlier than the first IDLE cycle.
- frames input changes while busy: no effect (latched copy used).
- J is 0 whenever bit_valid=0.
- Total cycles start-accept to done for N frames: N*PATTERN_W + (N-1)*GAP_CYCLES + 1 (plus 1 per frame with parity).

Optional Feature:
- Macro: SEQ_PATTERN_TX_PARITY_EN.
- Defined: after each frame's LSB, one extra cycle in SEND carries even parity (XOR of PATTERN) on J with bit_valid=1. Gap/FIN follow the parity bit.
- Undefined: no parity cycle; frame is exactly PATTERN_W bits.

Decomposition:
- Shared package seq_tx_pkg: state enum (IDLE/SEND/GAP/FIN), default PATTERN constant 8'b10000001, default widths.
- One natural sub-module: seq_tx_shifter (loadable PATTERN_W-bit MSB-first shift register with bit counter and last_bit flag). FSM and frame/gap counters stay in the top module.

Test Plan:
- Reset held 2 cycles then released, start=0 for 5 cycles -> J=0, bit_valid=0, busy=0, done=0 throughout.
- start=1 one cycle, frames=1 -> J=1,0,0,0,0,0,0,1 on the 8 cycles after acceptance; done pulse on cycle 9; loopback into s10000001detectorQ raises Y once.
- frames=3, GAP_CYCLES=2 -> three frames separated by exactly two J=0/bit_valid=0 cycles; done at cycle 3*8+2*2+1=29.
- frames=0 with start -> busy and done high the same single cycle; no bit_valid.
- rst driven low during frame bit 4 -> next cycle all outputs 0, state IDLE, no done; a new start then sends a full frame.
- start re-asserted while busy, and frames changed mid-transfer -> ignored; frame count unchanged. With SEQ_PATTERN_TX_PARITY_EN defined, frames=1 -> 9 valid bits, last = 0 (even parity of 10000001).
